// File: rtl/sobel_pkg.sv
// Shared widths, defaults and pipeline tag type for the Sobel gradient stage.
package sobel_pkg;
    localparam int PIX_W_DEF    = 16;
    localparam int OUT_W_DEF    = 8;
    localparam int H_ACTIVE_DEF = 180;
    localparam int V_ACTIVE_DEF = 120;
    localparam int AH_W         = 10;
    localparam int AV_W         = 9;

    // Tap weights sum to 4, so two bits of growth plus a sign bit.
    function automatic int grad_w(input int pix_w);
        return pix_w + 32'sd3;
    endfunction

    function automatic int mag_w(input int pix_w);
        return pix_w + 32'sd3;
    endfunction

    localparam int GRAD_W = grad_w(PIX_W_DEF);
    localparam int MAG_W  = mag_w(PIX_W_DEF);

    typedef struct packed {
        logic            valid;
        logic [AH_W-1:0] ah;
        logic [AV_W-1:0] av;
    } pipe_tag_t;
endpackage

// File: rtl/sobel_axis_grad.sv
// One Sobel axis: registered (p0+2p1+p2)-(n0+2n1+n2), then registered absolute value.
module sobel_axis_grad
    import sobel_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PIX_W-1:0] pos0_i,
    input  logic [PIX_W-1:0] pos1_i,
    input  logic [PIX_W-1:0] pos2_i,
    input  logic [PIX_W-1:0] neg0_i,
    input  logic [PIX_W-1:0] neg1_i,
    input  logic [PIX_W-1:0] neg2_i,
    output logic [PIX_W+1:0] abs_o
);
    localparam int GW = grad_w(PIX_W);
    localparam int AW = PIX_W + 2;

    logic [GW-1:0]        pos_sum_s;
    logic [GW-1:0]        neg_sum_s;
    logic signed [GW-1:0] grad_d;
    logic signed [GW-1:0] grad_q;
    logic [AW-1:0]        abs_d;
    logic [AW-1:0]        abs_q;

    // Weighted difference for S1 and magnitude of the S1 result for S2
    always_comb begin
        pos_sum_s = GW'(pos0_i) + GW'({pos1_i, 1'b0}) + GW'(pos2_i);
        neg_sum_s = GW'(neg0_i) + GW'({neg1_i, 1'b0}) + GW'(neg2_i);
        grad_d    = signed'(pos_sum_s - neg_sum_s);
        if (grad_q[GW-1]) begin
            abs_d = AW'(-grad_q);
        end else begin
            abs_d = AW'(grad_q);
        end
    end

    // S1 and S2 pipeline registers
    always_ff @(posedge clock) begin
        if (reset) begin
            grad_q <= {GW{1'b0}};
            abs_q  <= {AW{1'b0}};
        end else begin
            grad_q <= grad_d;
            abs_q  <= abs_d;
        end
    end

    assign abs_o = abs_q;
endmodule

// File: rtl/sobel_gradient.sv
// 3-stage Sobel |Gx|+|Gy| with saturation and border suppression.
// Optional binary edge output when SOBEL_THRESHOLD_EN is defined.
module sobel_gradient
    import sobel_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [AH_W-1:0]  AH,
    input  logic [AV_W-1:0]  AV,
    input  logic [PIX_W-1:0] sliding0,
    input  logic [PIX_W-1:0] sliding1,
    input  logic [PIX_W-1:0] sliding2,
    input  logic [PIX_W-1:0] sliding3,
    input  logic [PIX_W-1:0] sliding4,
    input  logic [PIX_W-1:0] sliding5,
    input  logic [PIX_W-1:0] sliding6,
    input  logic [PIX_W-1:0] sliding7,
    input  logic [PIX_W-1:0] sliding8,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [OUT_W-1:0] threshold,
`endif
    output logic             out_valid,
    output logic [AH_W-1:0]  out_AH,
    output logic [AV_W-1:0]  out_AV,
    output logic [OUT_W-1:0] out_pixel
);
    localparam int AW = PIX_W + 2;
    localparam int MW = mag_w(PIX_W);
    localparam int CW = ((MW > OUT_W) ? MW : OUT_W) + 1;
    localparam logic [CW-1:0]   OUT_MAX = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic [AH_W-1:0] AH_LO   = 10'd2;
    localparam logic [AV_W-1:0] AV_LO   = 9'd2;
    localparam logic [AH_W-1:0] AH_END  = AH_W'(H_ACTIVE);
    localparam logic [AV_W-1:0] AV_END  = AV_W'(V_ACTIVE);

    logic [AW-1:0]    abs_x_s;
    logic [AW-1:0]    abs_y_s;
    logic [MW-1:0]    mag_s;
    logic [CW-1:0]    wide_s;
    logic [OUT_W-1:0] sat_s;
    logic             border_s;
    logic [OUT_W-1:0] pixel_d;
    pipe_tag_t        tag_in_s;
    pipe_tag_t        tag1_q;
    pipe_tag_t        tag2_q;
    logic             out_valid_q;
    logic [AH_W-1:0]  out_ah_q;
    logic [AV_W-1:0]  out_av_q;
    logic [OUT_W-1:0] out_pixel_q;
    logic             unused_center_s;

    // The centre tap carries zero weight in both kernels.
    assign unused_center_s = ^sliding4;

    sobel_axis_grad #(.PIX_W(PIX_W)) u_grad_x (
        .clock  (clock),
        .reset  (reset),
        .pos0_i (sliding2),
        .pos1_i (sliding5),
        .pos2_i (sliding8),
        .neg0_i (sliding0),
        .neg1_i (sliding3),
        .neg2_i (sliding6),
        .abs_o  (abs_x_s)
    );

    sobel_axis_grad #(.PIX_W(PIX_W)) u_grad_y (
        .clock  (clock),
        .reset  (reset),
        .pos0_i (sliding6),
        .pos1_i (sliding7),
        .pos2_i (sliding8),
        .neg0_i (sliding0),
        .neg1_i (sliding1),
        .neg2_i (sliding2),
        .abs_o  (abs_y_s)
    );

    assign tag_in_s = '{valid: in_valid, ah: AH, av: AV};

    // S3 magnitude, saturation, border suppression and output selection
    always_comb begin
        mag_s    = MW'(abs_x_s) + MW'(abs_y_s);
        wide_s   = CW'(mag_s);
        if (wide_s > OUT_MAX) begin
            sat_s = {OUT_W{1'b1}};
        end else begin
            sat_s = wide_s[OUT_W-1:0];
        end
        border_s = (tag2_q.ah < AH_LO) || (tag2_q.av < AV_LO) ||
                   (tag2_q.ah >= AH_END) || (tag2_q.av >= AV_END);
        if (!tag2_q.valid || border_s) begin
            pixel_d = {OUT_W{1'b0}};
        end else begin
`ifdef SOBEL_THRESHOLD_EN
            if (sat_s >= threshold) begin
                pixel_d = {OUT_W{1'b1}};
            end else begin
                pixel_d = {OUT_W{1'b0}};
            end
`else
            pixel_d = sat_s;
`endif
        end
    end

    // Valid/coordinate delay line alongside the gradient stages, plus output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            tag1_q      <= '{valid: 1'b0, ah: {AH_W{1'b0}}, av: {AV_W{1'b0}}};
            tag2_q      <= '{valid: 1'b0, ah: {AH_W{1'b0}}, av: {AV_W{1'b0}}};
            out_valid_q <= 1'b0;
            out_ah_q    <= {AH_W{1'b0}};
            out_av_q    <= {AV_W{1'b0}};
            out_pixel_q <= {OUT_W{1'b0}};
        end else begin
            tag1_q      <= tag_in_s;
            tag2_q      <= tag1_q;
            out_valid_q <= tag2_q.valid;
            out_ah_q    <= tag2_q.ah;
            out_av_q    <= tag2_q.av;
            out_pixel_q <= pixel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_AH    = out_ah_q;
    assign out_AV    = out_av_q;
    assign out_pixel = out_pixel_q;
endmodule

// File: tb/tb_sobel_gradient.sv
// Directed bench: 8-bit taps into a 10-bit output build (dut_w) and an 8-bit output build (dut_n).
`timescale 1ns/1ps
module tb_sobel_gradient;
    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [9:0] ah_s;
    logic [8:0] av_s;
    logic [7:0] sl [9];
    logic       vw, vn;
    logic [9:0] ahw, ahn;
    logic [8:0] avw, avn;
    logic [9:0] pw;
    logic [7:0] pn;
`ifdef SOBEL_THRESHOLD_EN
    logic [9:0] thr_w = 10'd100;
    logic [7:0] thr_n = 8'd100;
`endif
    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sobel_gradient #(.PIX_W(8), .OUT_W(10)) dut_w (
        .clock(clock), .reset(reset), .in_valid(in_valid), .AH(ah_s), .AV(av_s),
        .sliding0(sl[0]), .sliding1(sl[1]), .sliding2(sl[2]), .sliding3(sl[3]), .sliding4(sl[4]),
        .sliding5(sl[5]), .sliding6(sl[6]), .sliding7(sl[7]), .sliding8(sl[8]),
`ifdef SOBEL_THRESHOLD_EN
        .threshold(thr_w),
`endif
        .out_valid(vw), .out_AH(ahw), .out_AV(avw), .out_pixel(pw));

    sobel_gradient #(.PIX_W(8), .OUT_W(8)) dut_n (
        .clock(clock), .reset(reset), .in_valid(in_valid), .AH(ah_s), .AV(av_s),
        .sliding0(sl[0]), .sliding1(sl[1]), .sliding2(sl[2]), .sliding3(sl[3]), .sliding4(sl[4]),
        .sliding5(sl[5]), .sliding6(sl[6]), .sliding7(sl[7]), .sliding8(sl[8]),
`ifdef SOBEL_THRESHOLD_EN
        .threshold(thr_n),
`endif
        .out_valid(vn), .out_AH(ahn), .out_AV(avn), .out_pixel(pn));

    // Hand-computed saturated magnitudes for each pattern (OUT_W=10 and OUT_W=8).
    function automatic int sat_w(input int p);
        case (p)
            1: return 400;   // vertical edge, Gx=400 Gy=0
            2: return 1023;  // Gx=765 Gy=765 -> 1530 saturates
            3: return 98;
            4: return 100;
            5: return 200;   // Gx=-200
            6: return 256;
            default: return 0;
        endcase
    endfunction

    function automatic int sat_n(input int p);
        case (p)
            1: return 255;
            2: return 255;
            3: return 98;
            4: return 100;
            5: return 200;
            6: return 255;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_w(input int p);
`ifdef SOBEL_THRESHOLD_EN
        return (sat_w(p) >= 100) ? 1023 : 0;
`else
        return sat_w(p);
`endif
    endfunction

    function automatic int exp_n(input int p);
`ifdef SOBEL_THRESHOLD_EN
        return (sat_n(p) >= 100) ? 255 : 0;
`else
        return sat_n(p);
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int p, input int ah, input int av);
        in_valid = v;
        ah_s     = 10'(ah);
        av_s     = 9'(av);
        for (int i = 0; i < 9; i++) sl[i] = 8'd0;
        case (p)
            0: for (int i = 0; i < 9; i++) sl[i] = 8'd50;
            1: begin
                sl[1] = 8'd50;  sl[4] = 8'd50;  sl[7] = 8'd50;
                sl[2] = 8'd100; sl[5] = 8'd100; sl[8] = 8'd100;
            end
            2: begin
                sl[2] = 8'd255; sl[5] = 8'd255; sl[8] = 8'd255;
                sl[6] = 8'd255; sl[7] = 8'd255;
            end
            3: sl[5] = 8'd49;
            4: sl[5] = 8'd50;
            5: sl[3] = 8'd100;
            6: sl[5] = 8'd128;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1, 50, 50);
        repeat (4) step();
        checks++;
        if (vw !== 1'b0 || vn !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b/%b want 0/0", vw, vn);
        end
        checks++;
        if (pw !== 10'd0 || pn !== 8'd0) begin
            failures++; $display("FAIL reset_pixel: got %0d/%0d want 0/0", pw, pn);
        end
        checks++;
        if (ahw !== 10'd0 || avw !== 9'd0 || ahn !== 10'd0 || avn !== 9'd0) begin
            failures++; $display("FAIL reset_coord: got %0d,%0d want 0,0", ahw, avw);
        end
        reset = 1'b0;
        drive(1'b0, 7, 0, 0);
        repeat (3) step();
    endtask

    task automatic test_latency();
        drive(1'b1, 0, 10, 10);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) drive(1'b0, 7, 0, 0);
            checks++;
            if (vw !== (c == 3) || vn !== (c == 3)) begin
                failures++; $display("FAIL latency_valid c=%0d: got %b/%b want %b", c, vw, vn, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (pw !== 10'd0 || pn !== 8'd0 || ahw !== 10'd10 || avw !== 9'd10) begin
                    failures++;
                    $display("FAIL uniform: got pix %0d/%0d at %0d,%0d want 0/0 at 10,10", pw, pn, ahw, avw);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            step();
            if (i >= 3) begin
                checks++;
                if (vw !== 1'b1 || vn !== 1'b1 || ahw !== 10'(17 + i) || avw !== 9'd40) begin
                    failures++;
                    $display("FAIL b2b_tag k=%0d: got v=%b/%b at %0d,%0d want 1 at %0d,40", i - 3, vw, vn, ahw, avw, 17 + i);
                end
                checks++;
                if (pw !== 10'(exp_w(i - 2))) begin
                    failures++; $display("FAIL b2b_pix_w pat=%0d: got %0d want %0d", i - 2, pw, exp_w(i - 2));
                end
                checks++;
                if (pn !== 8'(exp_n(i - 2))) begin
                    failures++; $display("FAIL b2b_pix_n pat=%0d: got %0d want %0d", i - 2, pn, exp_n(i - 2));
                end
            end
            if (i < 6) drive(1'b1, i + 1, 20 + i, 40);
            else drive(1'b0, 7, 0, 0);
        end
    endtask

    task automatic test_border();
        int bah [6] = '{1, 50, 180, 50, 2, 179};
        int bav [6] = '{50, 1, 50, 120, 2, 119};
        int bok [6] = '{0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 9; i++) begin
            step();
            if (i >= 3) begin
                checks++;
                if (vw !== 1'b1 || ahw !== 10'(bah[i-3]) || avw !== 9'(bav[i-3]) ||
                    ahn !== 10'(bah[i-3]) || avn !== 9'(bav[i-3])) begin
                    failures++;
                    $display("FAIL border_tag: got v=%b %0d,%0d want 1 %0d,%0d", vw, ahw, avw, bah[i-3], bav[i-3]);
                end
                checks++;
                if (pw !== 10'(bok[i-3] * exp_w(1)) || pn !== 8'(bok[i-3] * exp_n(1))) begin
                    failures++;
                    $display("FAIL border_pix at %0d,%0d: got %0d/%0d want %0d/%0d", bah[i-3], bav[i-3],
                             pw, pn, bok[i-3] * exp_w(1), bok[i-3] * exp_n(1));
                end
            end
            if (i < 6) drive(1'b1, 1, bah[i], bav[i]);
            else drive(1'b0, 7, 0, 0);
        end
    endtask

    task automatic test_invalid_gap();
        drive(1'b0, 1, 77, 33);
        step();
        drive(1'b0, 7, 0, 0);
        step();
        step();
        checks++;
        if (vw !== 1'b0 || pw !== 10'd0 || pn !== 8'd0 || ahw !== 10'd77 || avw !== 9'd33) begin
            failures++;
            $display("FAIL invalid_gap: got v=%b pix %0d/%0d at %0d,%0d want 0 0/0 at 77,33", vw, pw, pn, ahw, avw);
        end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b1, 1, 60 + i, 60);
        end
        step();
        checks++;
        if (vw !== 1'b1 || pw !== 10'(exp_w(1))) begin
            failures++; $display("FAIL flush_pre: got v=%b pix %0d want 1 %0d", vw, pw, exp_w(1));
        end
        reset = 1'b1;
        drive(1'b0, 7, 0, 0);
        step();
        checks++;
        if (vw !== 1'b0 || vn !== 1'b0 || pw !== 10'd0 || pn !== 8'd0 || ahw !== 10'd0) begin
            failures++; $display("FAIL flush_reset: got v=%b/%b pix %0d/%0d ah %0d want all 0", vw, vn, pw, pn, ahw);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (vw !== 1'b0 || vn !== 1'b0 || pw !== 10'd0 || pn !== 8'd0) begin
                failures++; $display("FAIL flush_stale c=%0d: got v=%b/%b pix %0d/%0d want 0", i, vw, vn, pw, pn);
            end
        end
    endtask

`ifdef SOBEL_THRESHOLD_EN
    task automatic test_threshold();
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 3) begin
                checks++;
                if (pw !== 10'd0 || pn !== 8'd0) begin
                    failures++; $display("FAIL thr_below: got %0d/%0d want 0/0", pw, pn);
                end
            end
            if (i == 4) begin
                checks++;
                if (pw !== 10'd1023 || pn !== 8'd255) begin
                    failures++; $display("FAIL thr_equal: got %0d/%0d want 1023/255", pw, pn);
                end
            end
            if (i < 2) drive(1'b1, 3 + i, 30, 30);
            else drive(1'b0, 7, 0, 0);
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        drive(1'b0, 7, 0, 0);
        test_reset();
        test_latency();
        test_back_to_back();
        test_border();
        test_invalid_gap();
        test_reset_flush();
`ifdef SOBEL_THRESHOLD_EN
        test_threshold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
